// File: rtl/note_judge.sv
// rtl/note_judge.sv - song-clock note timing judge (match / miss / stray events)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, stop         pulses: restart judging at song time 0 / halt to idle
//   btn[NUM_LANES]      debounced fret levels, 1 = pressed
//   note_valid/ready    chart FIFO handshake; note_time (ticks), note_lane
//   song_time           current song time in ticks
//   match_en, match_dt  hit pulse and absolute timing error at the hit
//   miss, stray         held note expired unhit / press matching no note
//   running             high while judging
module note_judge #(
    parameter int TICK_DIV  = 1000000,
    parameter int NUM_LANES = 5,
    parameter int WINDOW    = 100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [NUM_LANES-1:0] btn,
    input  logic                 note_valid,
    input  logic [31:0]          note_time,
    input  logic [2:0]           note_lane,
    output logic                 note_ready,
    output logic [31:0]          song_time,
    output logic                 match_en,
    output logic [15:0]          match_dt,
    output logic                 miss,
    output logic                 stray,
    output logic                 running
);

    localparam int              TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [32:0]     WIN       = 33'(WINDOW);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state;
    logic [TW-1:0]          tick_cnt;
    logic                   held;
    logic [31:0]            held_time;
    logic [2:0]             held_lane;
    logic [NUM_LANES-1:0]   btn_q;

    logic [NUM_LANES-1:0]   rise;
    logic [7:0]             rise_ext;
    logic                   lane_rise;
    logic [32:0]            diff;
    logic [32:0]            abs_d;
    logic                   accept;
    logic                   hit;
    logic                   expire;

    assign running    = (state == RUN);
    assign note_ready = running & ~held;
    assign accept     = note_valid & note_ready;

    // Lanes beyond NUM_LANES read as zero, so an out-of-range note can
    // never be hit and only leaves through the miss path.
    assign rise      = btn & ~btn_q;
    assign rise_ext  = 8'(rise);
    assign lane_rise = rise_ext[held_lane];

    // Zero-extended subtraction gives the exact signed 33-bit error even
    // when the two times are far apart.
    assign diff   = {1'b0, song_time} - {1'b0, held_time};
    assign abs_d  = diff[32] ? (33'd0 - diff) : diff;
    assign hit    = held & lane_rise & (abs_d < WIN);
    assign expire = held & ($signed(diff) >= $signed(WIN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            song_time <= '0;
            held      <= 1'b0;
            held_time <= '0;
            held_lane <= '0;
            btn_q     <= '0;
            match_en  <= 1'b0;
            match_dt  <= '0;
            miss      <= 1'b0;
            stray     <= 1'b0;
        end else begin
            btn_q    <= btn;
            match_en <= 1'b0;
            miss     <= 1'b0;
            stray    <= 1'b0;

            if (stop) begin
                // Any held (or just-handed-over) note is dropped silently.
                state <= IDLE;
                held  <= 1'b0;
            end else if (start) begin
                state     <= RUN;
                tick_cnt  <= '0;
                song_time <= '0;
                held      <= accept;
                if (accept) begin
                    held_time <= note_time;
                    held_lane <= note_lane;
                end
            end else if (state == RUN) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt  <= '0;
                    song_time <= song_time + 32'd1;
                end else begin
                    tick_cnt <= tick_cnt + TW'(1);
                end

                // accept needs held=0 while hit/expire need held=1, so
                // these branches never compete.
                if (accept) begin
                    held      <= 1'b1;
                    held_time <= note_time;
                    held_lane <= note_lane;
                end else if (hit) begin
                    match_en <= 1'b1;
                    match_dt <= abs_d[15:0];
                    held     <= 1'b0;
                end else if (expire) begin
                    miss <= 1'b1;
                    held <= 1'b0;
                end

                stray <= (|rise) & ~hit;
            end
        end
    end

endmodule

// File: tb/tb_note_judge.sv
// tb/tb_note_judge.sv - self-checking bench for note_judge
module tb_note_judge;

    localparam int TD  = 4;
    localparam int WIN = 100;
    localparam int NL  = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [4:0]  btn = '0;
    logic        note_valid = 1'b0;
    logic [31:0] note_time = '0;
    logic [2:0]  note_lane = '0;
    logic        note_ready;
    logic [31:0] song_time;
    logic        match_en;
    logic [15:0] match_dt;
    logic        miss;
    logic        stray;
    logic        running;

    note_judge #(.TICK_DIV(TD), .NUM_LANES(NL), .WINDOW(WIN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .btn(btn),
        .note_valid(note_valid), .note_time(note_time), .note_lane(note_lane),
        .note_ready(note_ready), .song_time(song_time), .match_en(match_en),
        .match_dt(match_dt), .miss(miss), .stray(stray), .running(running)
    );

    always #5 clk = ~clk;

    // Reference model: song time is simply elapsed run cycles / TD.
    bit          m_run, m_held;
    int unsigned m_cyc, m_time;
    logic [31:0] m_nt;
    logic [2:0]  m_nl;
    logic [4:0]  m_btnq;
    bit          e_match, e_miss, e_stray;
    logic [15:0] e_dt;

    int compared = 0;
    int mism = 0;
    int obs_match, obs_miss, obs_stray;
    logic [31:0] last_dt, miss_at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_held = 0; m_cyc = 0; m_time = 0; m_nt = '0; m_nl = '0;
        m_btnq = '0; e_match = 0; e_miss = 0; e_stray = 0; e_dt = '0;
    endtask

    task automatic clr_obs();
        obs_match = 0; obs_miss = 0; obs_stray = 0; last_dt = '0; miss_at = '0;
    endtask

    task automatic step();
        logic [4:0] rise;
        bit acc, hit, expd;
        longint d, ad;
        chk("note_ready_pre", note_ready, 32'(m_run && !m_held));
        rise = btn & ~m_btnq;
        acc  = m_run && !m_held && note_valid;
        @(posedge clk);
        m_btnq = btn;
        e_match = 0; e_miss = 0; e_stray = 0;
        if (stop) begin
            m_run = 0; m_held = 0;
        end else if (start) begin
            m_run = 1; m_cyc = 0; m_held = acc;
            if (acc) begin m_nt = note_time; m_nl = note_lane; end
        end else if (m_run) begin
            d    = longint'(m_time) - longint'(m_nt);
            ad   = (d < 0) ? -d : d;
            hit  = m_held && (m_nl < NL) && (((rise >> m_nl) & 5'd1) != 0) && (ad < WIN);
            expd = m_held && (d >= WIN);
            if (hit) begin e_match = 1; e_dt = ad[15:0]; m_held = 0; end
            else if (expd) begin e_miss = 1; m_held = 0; end
            e_stray = (rise != 0) && !hit;
            if (acc) begin m_held = 1; m_nt = note_time; m_nl = note_lane; end
            m_cyc++;
        end
        if (m_run) m_time = m_cyc / TD;
        #1;
        chk("song_time", song_time, m_time);
        chk("running", 32'(running), 32'(m_run));
        chk("match_en", 32'(match_en), 32'(e_match));
        chk("match_dt", 32'(match_dt), 32'(e_dt));
        chk("miss", 32'(miss), 32'(e_miss));
        chk("stray", 32'(stray), 32'(e_stray));
        if (match_en) begin obs_match++; last_dt = 32'(match_dt); end
        if (miss) begin obs_miss++; miss_at = song_time; end
        if (stray) obs_stray++;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic press(input logic [4:0] b);
        btn = b; step(); btn = '0; step();
    endtask

    task automatic run_to(input int unsigned t);
        for (int i = 0; i < 4000 && m_time != t; i++) step();
        chk("run_to_time", song_time, t);
    endtask

    task automatic push_note(input logic [31:0] t, input logic [2:0] l);
        bit done;
        done = 0;
        note_valid = 1'b1; note_time = t; note_lane = l;
        for (int i = 0; i < 8 && !done; i++) begin
            done = m_run && !m_held;
            step();
        end
        note_valid = 1'b0;
        chk("push_accepted", 32'(done), 32'd1);
    endtask

    initial begin
        model_reset();
        clr_obs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset in the middle of RUN with a held note.
        pulse_start();
        push_note(32'd1000, 3'd0);
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_song_time", song_time, 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_ready", 32'(note_ready), 32'd0);
        chk("rst_match", 32'({match_en, miss, stray}), 32'd0);
        chk("rst_dt", 32'(match_dt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulse_start();
        repeat (8) step();
        chk("tick_rate", song_time, 32'd2);

        // Hit at error 3; note_ready returns the cycle after the hit.
        pulse_start();
        clr_obs();
        push_note(32'd200, 3'd2);
        run_to(203);
        btn = 5'b00100; step();
        chk("s2_ready_again", 32'(note_ready), 32'd1);
        btn = '0; step();
        chk("s2_match_cnt", obs_match, 32'd1);
        chk("s2_dt", last_dt, 32'd3);

        // Unhit note expires exactly once at song_time 300.
        pulse_start();
        clr_obs();
        push_note(32'd200, 3'd0);
        run_to(310);
        chk("s3_miss_cnt", obs_miss, 32'd1);
        chk("s3_miss_at", miss_at, 32'd300);
        chk("s3_match_cnt", obs_match, 32'd0);

        // Too early is a stray and keeps the note; later press hits.
        pulse_start();
        clr_obs();
        push_note(32'd500, 3'd1);
        run_to(350);
        press(5'b00010);
        chk("s4_stray_cnt", obs_stray, 32'd1);
        chk("s4_still_held", 32'(note_ready), 32'd0);
        run_to(450);
        press(5'b00010);
        chk("s4_match_cnt", obs_match, 32'd1);
        chk("s4_dt", last_dt, 32'd50);

        // Wrong lane is a stray; chord containing the lane is a clean hit.
        pulse_start();
        clr_obs();
        run_to(100);
        push_note(32'd100, 3'd3);
        press(5'b10000);
        chk("s5_stray_cnt", obs_stray, 32'd1);
        press(5'b11000);
        chk("s5_match_cnt", obs_match, 32'd1);
        chk("s5_stray_after_chord", obs_stray, 32'd1);

        // Stop discards the note silently and freezes time; restart.
        pulse_start();
        clr_obs();
        push_note(32'd500, 3'd0);
        run_to(120);
        pulse_stop();
        chk("s6_running", 32'(running), 32'd0);
        repeat (20) step();
        chk("s6_frozen", song_time, 32'd120);
        chk("s6_no_miss", obs_miss, 32'd0);
        note_valid = 1'b1; note_time = 32'd50; note_lane = 3'd1;
        start = 1'b1; step(); start = 1'b0;
        chk("s6_restart_time", song_time, 32'd0);
        step();
        note_valid = 1'b0;
        chk("s6_accepted", 32'(note_ready), 32'd0);

        // Randomized traffic against the model, including window edges.
        pulse_start();
        for (int i = 0; i < 4000; i++) begin
            int t;
            if ($urandom_range(0, 5) == 0) btn = 5'($urandom);
            note_valid = ($urandom_range(0, 3) != 0);
            t = int'(m_time) + int'($urandom_range(0, 240)) - 120;
            if (t < 0) t = 0;
            note_time = 32'(t);
            note_lane = 3'($urandom_range(0, 6));
            start = ($urandom_range(0, 699) == 0);
            stop  = ($urandom_range(0, 899) == 0);
            if (!m_run && $urandom_range(0, 9) == 0) start = 1'b1;
            step();
        end
        start = 1'b0; stop = 1'b0; note_valid = 1'b0; btn = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
